// File: rtl/cpu_joypad_ports.sv
// NES controller ports on the CPU bus: $4016 strobe write, $4016/$4017 serial reads.
// Raw buttons pass through a synchroniser and an optional debounce before they are latched.
module cpu_joypad_ports #(
    parameter int          NUM_PORTS       = 2,
    parameter int          NUM_BUTTONS     = 8,
    parameter logic        FILL_BIT        = 1'b1,
    parameter logic [7:0]  OPEN_BUS        = 8'h40,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 0
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             clock_en,
    input  logic [15:0]                      addr,
    input  logic                             r_en,
    input  logic [7:0]                       w_data,
    input  logic [NUM_PORTS*NUM_BUTTONS-1:0] buttons_in,
    output logic                             rd_hit,
    output logic [7:0]                       rd_data,
    output logic                             strobe
);

    localparam int NB = NUM_PORTS * NUM_BUTTONS;

    logic [NB-1:0]          sync_q [SYNC_STAGES];
    logic [NB-1:0]          synced;
    logic [NB-1:0]          btn;
    logic [NUM_BUTTONS-1:0] sr [NUM_PORTS];
    logic [NUM_PORTS-1:0]   hit;
    logic                   wr_strobe;
    logic                   reload;
    logic                   rd_bit;

    // Input path is free-running on every clock, independent of clock_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= buttons_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign btn = synced;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            for (genvar b = 0; b < NB; b++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          deb;
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt <= '0;
                        deb <= 1'b0;
                    end else if (synced[b] != deb) begin
                        if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                            deb <= synced[b];
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                assign btn[b] = deb;
            end
        end
    endgenerate

    assign wr_strobe = clock_en && !r_en && (addr == 16'h4016);
    // A write raising strobe loads immediately; an already-high strobe keeps reloading.
    assign reload    = clock_en && (strobe || (wr_strobe && w_data[0]));

    always_comb begin
        hit    = '0;
        rd_bit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hit[p] = clock_en && r_en && (addr == 16'h4016 + 16'(p));
            if (hit[p]) rd_bit = sr[p][0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe  <= 1'b0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
            for (int p = 0; p < NUM_PORTS; p++) sr[p] <= '0;
        end else begin
            if (wr_strobe) strobe <= w_data[0];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (reload)
                    sr[p] <= btn[p*NUM_BUTTONS +: NUM_BUTTONS];
                else if (hit[p])
                    sr[p] <= {FILL_BIT, sr[p][NUM_BUTTONS-1:1]};
            end
            if (clock_en) begin
                rd_hit <= |hit;
                if (|hit) rd_data <= {OPEN_BUS[7:1], rd_bit};
            end
        end
    end

endmodule
